// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states and read-return ownership.
// No logic of its own; imported by the arbiter and its round-robin picker.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        HLOCK   = 2'd1,
        RELEASE = 2'd2
    } arb_state;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } mem_owner;

    function automatic mem_owner other_side(input mem_owner o);
        return (o == OWN_CORE) ? OWN_HOST : OWN_CORE;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: one-hot grant from two requests and a priority pointer.
// Purely combinational; a lone request always wins and leaves priority with the idle side.
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic c_req,
    input  logic h_req,
    input  logic prio,
    output logic c_pick,
    output logic h_pick,
    output logic prio_nxt
);

    always_comb begin
        c_pick   = 1'b0;
        h_pick   = 1'b0;
        prio_nxt = prio;
        if (c_req && h_req) begin
            if (prio == OWN_CORE) c_pick = 1'b1;
            else                  h_pick = 1'b1;
            prio_nxt = other_side(mem_owner'(prio));
        end else if (c_req) begin
            c_pick   = 1'b1;
            prio_nxt = OWN_HOST;
        end else if (h_req) begin
            h_pick   = 1'b1;
            prio_nxt = OWN_CORE;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between core and host; grant and memory command same cycle.
// Read data returns one cycle after grant; an ungranted requester must hold its request.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    input  logic          h_lock,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic          m_loadEn,
    output logic          m_storEn,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_storData,
    input  logic [DW-1:0] m_loadData,
    output logic          lock_active
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state      state;
    mem_owner      prio;
    logic [CW-1:0] lock_cnt;
    logic [DW-1:0] c_rdata_q;
    logic [DW-1:0] h_rdata_q;
    logic          pick_c;
    logic          pick_h;
    logic          prio_rr;

    dmem_rr_pick u_pick (
        .c_req    (c_req),
        .h_req    (h_req),
        .prio     (prio),
        .c_pick   (pick_c),
        .h_pick   (pick_h),
        .prio_nxt (prio_rr)
    );

    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        case (state)
            ARB: begin
                c_gnt = pick_c;
                h_gnt = pick_h;
            end
            HLOCK: h_gnt = h_req;
            RELEASE: begin
                c_gnt = c_req;
                h_gnt = h_req & ~c_req;
            end
            default: ;
        endcase
    end

    always_comb begin
        m_storEn   = (c_gnt & c_we) | (h_gnt & h_we);
        m_loadEn   = (c_gnt & ~c_we) | (h_gnt & ~h_we);
        m_addr     = c_gnt ? c_addr  : (h_gnt ? h_addr  : '0);
        m_storData = c_gnt ? c_wdata : (h_gnt ? h_wdata : '0);
    end

    // Memory data is live during the return cycle, so bypass the holding register then.
    assign c_rdata = c_rvalid ? m_loadData : c_rdata_q;
    assign h_rdata = h_rvalid ? m_loadData : h_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB;
            prio        <= OWN_CORE;
            lock_cnt    <= '0;
            lock_active <= 1'b0;
            c_rvalid    <= 1'b0;
            h_rvalid    <= 1'b0;
            c_rdata_q   <= '0;
            h_rdata_q   <= '0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            h_rvalid <= h_gnt & ~h_we;
            if (c_rvalid) c_rdata_q <= m_loadData;
            if (h_rvalid) h_rdata_q <= m_loadData;

            case (state)
                ARB: begin
                    prio <= mem_owner'(prio_rr);
                    if (h_gnt && h_lock) begin
                        state       <= HLOCK;
                        lock_cnt    <= CW'(1);
                        lock_active <= 1'b1;
                    end
                end
                HLOCK: begin
                    if (!h_lock) begin
                        state       <= ARB;
                        prio        <= OWN_CORE;
                        lock_cnt    <= '0;
                        lock_active <= 1'b0;
                    end else if (lock_cnt == CW'(LOCK_MAX - 1)) begin
                        // The cycle that would make LOCK_MAX host cycles is the last one.
                        state       <= RELEASE;
                        lock_cnt    <= '0;
                        lock_active <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    state <= ARB;
                    prio  <= c_gnt ? OWN_HOST : OWN_CORE;
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       c_req = 0, c_we = 0, h_req = 0, h_we = 0, h_lock = 0;
    logic [7:0] c_addr = 0, c_wdata = 0, h_addr = 0, h_wdata = 0;
    logic       c_gnt, c_rvalid, h_gnt, h_rvalid, m_loadEn, m_storEn, lock_active;
    logic [7:0] c_rdata, h_rdata, m_addr, m_storData;
    logic [7:0] m_loadData = 8'h00;
    logic [7:0] mem [256];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_storEn) mem[m_addr] <= m_storData;
        if (m_loadEn) m_loadData <= mem[m_addr];
    end

    dmem_arbiter #(.AW(8), .DW(8), .LOCK_MAX(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_loadEn(m_loadEn), .m_storEn(m_storEn), .m_addr(m_addr),
        .m_storData(m_storData), .m_loadData(m_loadData), .lock_active(lock_active)
    );

    task automatic idle_inputs();
        c_req = 0; c_we = 0; h_req = 0; h_we = 0; h_lock = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        total++; if ({c_rvalid, h_rvalid, lock_active} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {c_rvalid, h_rvalid, lock_active}); end
        total++; if ({c_rdata, h_rdata} !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", {c_rdata, h_rdata}); end
        total++; if ({c_gnt, h_gnt, m_loadEn, m_storEn, m_addr, m_storData} !== 20'h0) begin bad++; $display("FAIL reset_mcmd got=%h exp=0", {c_gnt, h_gnt, m_loadEn, m_storEn, m_addr, m_storData}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_core_read();
        mem[8'h10] = 8'h5A;
        @(negedge clk);
        c_req = 1; c_we = 0; c_addr = 8'h10;
        #1;
        total++; if ({c_gnt, h_gnt, m_loadEn, m_storEn} !== 4'b1010) begin bad++; $display("FAIL core_rd_cmd got=%b exp=1010", {c_gnt, h_gnt, m_loadEn, m_storEn}); end
        total++; if (m_addr !== 8'h10) begin bad++; $display("FAIL core_rd_addr got=%h exp=10", m_addr); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if ({c_rvalid, h_rvalid, c_gnt} !== 3'b100) begin bad++; $display("FAIL core_rd_valid got=%b exp=100", {c_rvalid, h_rvalid, c_gnt}); end
        total++; if (c_rdata !== 8'h5A) begin bad++; $display("FAIL core_rd_data got=%h exp=5a", c_rdata); end
        @(negedge clk);
        #1;
        total++; if (c_rvalid !== 1'b0 || c_rdata !== 8'h5A) begin bad++; $display("FAIL core_rd_hold got=%b/%h exp=0/5a", c_rvalid, c_rdata); end
    endtask

    task automatic test_contention();
        logic exp_c;
        mem[8'h40] = 8'hA0;
        mem[8'h41] = 8'hB1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            c_req = (i < 4); c_we = 0; c_addr = 8'h40;
            h_req = (i < 4); h_we = 0; h_addr = 8'h41;
            #1;
            if (i < 4) begin
                exp_c = (i % 2 == 0);
                total++; if ({c_gnt, h_gnt} !== {exp_c, ~exp_c}) begin bad++; $display("FAIL cont_gnt cyc=%0d got=%b exp=%b", i, {c_gnt, h_gnt}, {exp_c, ~exp_c}); end
                total++; if (m_addr !== (exp_c ? 8'h40 : 8'h41)) begin bad++; $display("FAIL cont_addr cyc=%0d got=%h", i, m_addr); end
            end
            if (i > 0) begin
                exp_c = (i % 2 == 1);
                total++; if ({c_rvalid, h_rvalid} !== {exp_c, ~exp_c}) begin bad++; $display("FAIL cont_rvalid cyc=%0d got=%b exp=%b", i, {c_rvalid, h_rvalid}, {exp_c, ~exp_c}); end
                total++; if ((exp_c ? c_rdata : h_rdata) !== (exp_c ? 8'hA0 : 8'hB1)) begin bad++; $display("FAIL cont_rdata cyc=%0d got=%h/%h", i, c_rdata, h_rdata); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        @(negedge clk);
        h_req = 1; h_we = 1; h_addr = 8'h20; h_wdata = 8'h33;
        #1;
        total++; if ({h_gnt, m_storEn, m_loadEn} !== 3'b110 || m_addr !== 8'h20 || m_storData !== 8'h33) begin bad++; $display("FAIL wr_cmd got=%b %h %h exp=110 20 33", {h_gnt, m_storEn, m_loadEn}, m_addr, m_storData); end
        @(negedge clk);
        h_req = 0; h_we = 0;
        c_req = 1; c_we = 0; c_addr = 8'h20;
        #1;
        total++; if ({c_gnt, m_storEn, m_loadEn, h_rvalid} !== 4'b1010 || m_addr !== 8'h20) begin bad++; $display("FAIL rd_after_wr_cmd got=%b %h exp=1010 20", {c_gnt, m_storEn, m_loadEn, h_rvalid}, m_addr); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (c_rvalid !== 1'b1 || c_rdata !== 8'h33) begin bad++; $display("FAIL rd_after_wr_data got=%b/%h exp=1/33", c_rvalid, c_rdata); end
    endtask

    task automatic test_lock();
        logic exp_c, exp_h, exp_l;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            h_req = 1; h_we = 0; h_addr = 8'h41; h_lock = (i < 16);
            c_req = (i >= 1); c_we = 0; c_addr = 8'h40;
            #1;
            exp_l = (i >= 1 && i <= 15);
            if (i <= 15)       begin exp_c = 0; exp_h = 1; end
            else if (i == 16)  begin exp_c = 1; exp_h = 0; end
            else               begin exp_c = (i == 18); exp_h = (i != 18); end
            total++; if ({c_gnt, h_gnt, lock_active} !== {exp_c, exp_h, exp_l}) begin bad++; $display("FAIL lock_gnt cyc=%0d got=%b exp=%b", i, {c_gnt, h_gnt, lock_active}, {exp_c, exp_h, exp_l}); end
            if (i == 1) begin
                total++; if (h_rvalid !== 1'b1 || h_rdata !== 8'hB1) begin bad++; $display("FAIL lock_rdata got=%b/%h exp=1/b1", h_rvalid, h_rdata); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_lock_drop();
        logic exp_c;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            h_req = 1; h_we = 0; h_addr = 8'h41; h_lock = (i < 2);
            c_req = (i >= 1); c_we = 0; c_addr = 8'h40;
            #1;
            exp_c = (i == 3);
            total++; if ({c_gnt, h_gnt, lock_active} !== {exp_c, ~exp_c, (i == 1 || i == 2)}) begin bad++; $display("FAIL lockdrop cyc=%0d got=%b exp=%b", i, {c_gnt, h_gnt, lock_active}, {exp_c, ~exp_c, (i == 1 || i == 2)}); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midlock();
        do_reset();
        @(negedge clk);
        h_req = 1; h_we = 0; h_addr = 8'h41; h_lock = 1;
        @(negedge clk);
        #1;
        total++; if ({h_gnt, lock_active, h_rvalid} !== 3'b111) begin bad++; $display("FAIL midlock_pre got=%b exp=111", {h_gnt, lock_active, h_rvalid}); end
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        total++; if ({h_rvalid, c_rvalid, lock_active, h_gnt, m_loadEn} !== 5'b0 || h_rdata !== 8'h00) begin bad++; $display("FAIL midlock_async got=%b/%h exp=00000/00", {h_rvalid, c_rvalid, lock_active, h_gnt, m_loadEn}, h_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++; if ({h_rvalid, c_rvalid, lock_active} !== 3'b000) begin bad++; $display("FAIL midlock_after got=%b exp=000", {h_rvalid, c_rvalid, lock_active}); end
        @(negedge clk);
        c_req = 1; c_addr = 8'h40; h_req = 1; h_addr = 8'h41;
        #1;
        total++; if ({c_gnt, h_gnt} !== 2'b10) begin bad++; $display("FAIL midlock_first_gnt got=%b exp=10", {c_gnt, h_gnt}); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_contention();
        test_write_read();
        test_lock();
        test_lock_drop();
        test_reset_midlock();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the CPU core's load/store path and a host/loader port that preloads operands and reads results. Grants at most one access per cycle, drives the memory command, and returns read data to the owning requester. Sits between the control logic and the data memory; the core stalls while its request is not granted.

Parameters:
AW, 8, address width (matches 8-bit ra/rb addressing)
DW, 8, data width
LOCK_MAX, 16, max consecutive host-locked cycles before forced release (≥2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
c_req  in  1  core access request
c_we  in  1  core write (1) / read (0)
c_addr  in  AW  core address
c_wdata  in  DW  core store data
c_gnt  out  1  core access accepted this cycle (comb.)
c_rvalid  out  1  core read data valid
c_rdata  out  DW  core read data
h_req  in  1  host access request
h_we  in  1  host write / read
h_addr  in  AW  host address
h_wdata  in  DW  host store data
h_lock  in  1  host requests exclusive burst ownership
h_gnt  out  1  host access accepted this cycle (comb.)
h_rvalid  out  1  host read data valid
h_rdata  out  DW  host read data
m_loadEn  out  1  memory read enable
m_storEn  out  1  memory write enable
m_addr  out  AW  memory address
m_storData  out  DW  memory write data
m_loadData  in  DW  memory read data, valid cycle after m_loadEn
lock_active  out  1  host lock in force

Behaviour:
- Reset (rst_n low, async): state ARB, prio pointer = CORE, lock counter 0, c_rvalid/h_rvalid 0, c_rdata/h_rdata 0, lock_active 0. Gnt and m_* are combinational and 0 while no request.
- Single clock domain clk; all state updates on rising edge.
- FSM states: ARB, HLOCK, RELEASE.
- ARB: only one req -> grant it. Both req -> grant requester named by prio; prio then flips to the other. Single grant leaves prio pointing at the non-granted side. h_req & h_lock granted in ARB -> next state HLOCK, counter=1.
- HLOCK: h_gnt = h_req, c_gnt = 0, lock_active=1. Counter increments per cycle. h_lock low -> ARB with prio = CORE. Counter reaches LOCK_MAX -> RELEASE.
- RELEASE: one cycle, core has absolute priority (c_gnt=c_req, h_gnt = h_req & ~c_req); then ARB with prio = HOST only if core was granted, else CORE. h_lock ignored in RELEASE; reasserting it in ARB re-enters HLOCK.
- Memory command: same cycle as grant. m_addr/m_storData from granted requester; m_storEn = gnt & we; m_loadEn = gnt & ~we. No grant -> m_* all 0.
- Read return: 1-cycle latency. Owner tag registered at grant of a read; next cycle owner's rvalid=1 for exactly one cycle and rdata captures m_loadData; other side's rvalid=0, rdata holds last value.
- Back-to-back reads from alternating requesters each return in order, one per cycle; no bubbles.
- Write then read same address in consecutive cycles: read returns new data (memory write-first ordering is the memory's; arbiter adds no reordering).
- Requester may change addr/we freely while not granted; request held until gnt (gnt only sampled with req).
- Reset mid-lock or with read outstanding: all state cleared, pending rvalid dropped.

Decomposition:
- instr_pack (shared package) gains: typedef enum {ARB, HLOCK, RELEASE} arb_state; typedef enum logic {OWN_CORE, OWN_HOST} mem_owner.
- One sub-module natural: dmem_rr_pick (2-way round-robin picker: reqs + prio -> one-hot grant, next prio). Remaining FSM, counter, return path in dmem_arbiter.

Test Plan:
- Core only: c_req read addr 0x10, mem holds 0x5A -> c_gnt same cycle, m_loadEn=1 m_addr=0x10, next cycle c_rvalid=1 c_rdata=0x5A, h_rvalid=0.
- Contention: both req every cycle for 4 cycles from reset -> grants C,H,C,H; each rvalid routed to correct side one cycle later.
- Host write 0x33 to 0x20, core read 0x20 next cycle -> m_storEn then m_loadEn, c_rdata=0x33.
- Lock: h_lock+h_req held, c_req held, LOCK_MAX=16 -> h_gnt 16 cycles, lock_active 1, RELEASE cycle gives c_gnt=1 h_gnt=0, then ARB alternation resumes.
- Lock drop early: h_lock low after 3 cycles -> ARB, next contention grants core first.
- Async reset asserted during HLOCK with read outstanding -> outputs immediately 0, no rvalid after release, first contention grants core.
